// File: rtl/spad_pkg.sv
// Shared definitions for the ping-pong scratch pad.
// Holds the write-target step codes and the read sequencer state type.
package spad_pkg;

    localparam logic [2:0] STEP_LOAD_ACT = 3'd1;
    localparam logic [2:0] STEP_LOAD_WGT = 3'd2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/spad_lane_ram.sv
// One scratch-pad lane: DEPTH x LANE_W simple dual-port memory.
// Ports: clk; we_lo_i/we_hi_i write the low/high 32-bit half of entry
// waddr_i with wdata_i; raddr_i is read every cycle, rdata_o one cycle later.
module spad_lane_ram #(
    parameter int DEPTH  = 16,
    parameter int LANE_W = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_lo_i,
    input  logic              we_hi_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [LANE_W-1:0] rdata_o
);

    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_lo_i) mem_q[waddr_i][31:0]  <= wdata_i;
        if (we_hi_i) mem_q[waddr_i][63:32] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scratch_pad_pp.sv
// Ping-pong scratch pad: two banks of activation/weight lanes, one is
// loaded while the other is burst-read. Ports: clk, rst_n (sync, low);
// write side step/bram_num/wr_valid/wr_addr/data_received -> wr_err;
// swap/load_bank bank control; rd_start/rd_len burst read producing
// rd_busy/rd_valid/rd_done with data_out_a (act) and data_out_b (wgt).
// Define SCRATCH_PAD_PP_OUTREG_EN to add an output register (latency 2).
module scratch_pad_pp
    import spad_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2:0]                       step,
    input  logic [5:0]                       bram_num,
    input  logic                             wr_valid,
    input  logic [$clog2(DEPTH):0]           wr_addr,
    input  logic [31:0]                      data_received,
    input  logic                             swap,
    input  logic                             rd_start,
    input  logic [$clog2(DEPTH):0]           rd_len,
    output logic                             load_bank,
    output logic                             rd_busy,
    output logic                             rd_valid,
    output logic                             rd_done,
    output logic                             wr_err,
    output logic [SYS_HEIGHT*4*WIDTH-1:0]    data_out_a,
    output logic [SYS_WIDTH*4*WIDTH-1:0]     data_out_b
);

    localparam int LANE_W = 4 * WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] A_ONE   = AW'(1);

    rd_state_e   state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q;
    logic          load_bank_q, pend_q, wr_err_q;
    logic          issue_q, last_q;

    logic [AW:0]   len_d;
    logic          start_ok, issue_d, last_d;
    logic [AW-1:0] raddr_d;
    logic          wr_act, wr_wgt, wr_bad;
    logic          rd_valid_s, rd_done_s;

    always_comb begin
        len_d    = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;
        start_ok = (state_q == RD_IDLE) && rd_start && (rd_len != '0);
        // Address 0 is issued in the rd_start cycle itself.
        issue_d  = start_ok || (state_q == RD_RUN);
        raddr_d  = (state_q == RD_RUN) ? addr_q : '0;
        last_d   = 1'b0;
        if (start_ok)
            last_d = (len_d == LEN_ONE);
        else if (state_q == RD_RUN)
            last_d = ({1'b0, addr_q} == (len_q - LEN_ONE));
    end

    always_comb begin
        wr_act = wr_valid && (step == STEP_LOAD_ACT)
              && ({1'b0, bram_num} < 7'(SYS_HEIGHT));
        wr_wgt = wr_valid && (step == STEP_LOAD_WGT)
              && ({1'b0, bram_num} < 7'(SYS_WIDTH));
        wr_bad = wr_valid && !(wr_act || wr_wgt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            load_bank_q <= 1'b0;
            pend_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            issue_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            issue_q <= issue_d;
            last_q  <= last_d;
            if (wr_bad) wr_err_q <= 1'b1;
            unique case (state_q)
                RD_IDLE: begin
                    if (start_ok) begin
                        len_q   <= len_d;
                        addr_q  <= A_ONE;
                        pend_q  <= swap;
                        state_q <= last_d ? RD_DRAIN : RD_RUN;
                    end else if (swap) begin
                        load_bank_q <= ~load_bank_q;
                    end
                end
                RD_RUN: begin
                    if (swap) pend_q <= 1'b1;
                    if (last_d) state_q <= RD_DRAIN;
                    else        addr_q  <= addr_q + A_ONE;
                end
                RD_DRAIN: begin
                    if (rd_done_s) begin
                        state_q <= RD_IDLE;
                        pend_q  <= 1'b0;
                        if (pend_q || swap)
                            load_bank_q <= ~load_bank_q;
                    end else if (swap) begin
                        pend_q <= 1'b1;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    logic [LANE_W-1:0] act_rd [2][SYS_HEIGHT];
    logic [LANE_W-1:0] wgt_rd [2][SYS_WIDTH];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar i = 0; i < SYS_HEIGHT; i++) begin : g_act
            logic sel;
            assign sel = wr_act && (load_bank_q == 1'(b))
                      && (bram_num == 6'(i));
            spad_lane_ram #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_ram (
                .clk     (clk),
                .we_lo_i (sel && !wr_addr[0]),
                .we_hi_i (sel &&  wr_addr[0]),
                .waddr_i (wr_addr[AW:1]),
                .wdata_i (data_received),
                .raddr_i (raddr_d),
                .rdata_o (act_rd[b][i])
            );
        end
        for (genvar i = 0; i < SYS_WIDTH; i++) begin : g_wgt
            logic sel;
            assign sel = wr_wgt && (load_bank_q == 1'(b))
                      && (bram_num == 6'(i));
            spad_lane_ram #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_ram (
                .clk     (clk),
                .we_lo_i (sel && !wr_addr[0]),
                .we_hi_i (sel &&  wr_addr[0]),
                .waddr_i (wr_addr[AW:1]),
                .wdata_i (data_received),
                .raddr_i (raddr_d),
                .rdata_o (wgt_rd[b][i])
            );
        end
    end

    // load_bank cannot move between issue and last data, so the
    // current read bank is valid for every returning word.
    logic rd_bank;
    logic [SYS_HEIGHT*LANE_W-1:0] rd_a;
    logic [SYS_WIDTH*LANE_W-1:0]  rd_b;

    assign rd_bank = ~load_bank_q;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < SYS_HEIGHT; i++)
            rd_a[LANE_W*i +: LANE_W] = act_rd[rd_bank][i];
        for (int i = 0; i < SYS_WIDTH; i++)
            rd_b[LANE_W*i +: LANE_W] = wgt_rd[rd_bank][i];
    end

    logic [SYS_HEIGHT*LANE_W-1:0] hold_a_q;
    logic [SYS_WIDTH*LANE_W-1:0]  hold_b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else if (issue_q) begin
            hold_a_q <= rd_a;
            hold_b_q <= rd_b;
        end
    end

`ifdef SCRATCH_PAD_PP_OUTREG_EN
    logic valid2_q, done2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid2_q <= 1'b0;
            done2_q  <= 1'b0;
        end else begin
            valid2_q <= issue_q;
            done2_q  <= last_q;
        end
    end

    assign rd_valid_s = valid2_q;
    assign rd_done_s  = done2_q;
    assign data_out_a = hold_a_q;
    assign data_out_b = hold_b_q;
`else
    // Bypass the hold register on the valid cycle; it holds otherwise.
    assign rd_valid_s = issue_q;
    assign rd_done_s  = last_q;
    assign data_out_a = issue_q ? rd_a : hold_a_q;
    assign data_out_b = issue_q ? rd_b : hold_b_q;
`endif

    assign load_bank = load_bank_q;
    assign rd_busy   = (state_q != RD_IDLE);
    assign rd_valid  = rd_valid_s;
    assign rd_done   = rd_done_s;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_scratch_pad_pp.sv
// Scoreboard bench for scratch_pad_pp: directed writes, swaps and bursts;
// expected read words are queued at stimulus time, a monitor pops them.
module tb_scratch_pad_pp;

    localparam int WIDTH = 16, DEPTH = 16, SYS_HEIGHT = 1, SYS_WIDTH = 8;
    localparam int AW = 4;
`ifdef SCRATCH_PAD_PP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] step;
    logic [5:0] bram_num;
    logic wr_valid;
    logic [AW:0] wr_addr;
    logic [31:0] data_received;
    logic swap, rd_start;
    logic [AW:0] rd_len;
    logic load_bank, rd_busy, rd_valid, rd_done, wr_err;
    logic [SYS_HEIGHT*64-1:0] data_out_a;
    logic [SYS_WIDTH*64-1:0]  data_out_b;

    scratch_pad_pp #(
        .WIDTH(WIDTH), .DEPTH(DEPTH),
        .SYS_HEIGHT(SYS_HEIGHT), .SYS_WIDTH(SYS_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .bram_num(bram_num),
        .wr_valid(wr_valid), .wr_addr(wr_addr),
        .data_received(data_received), .swap(swap),
        .rd_start(rd_start), .rd_len(rd_len), .load_bank(load_bank),
        .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_done(rd_done),
        .wr_err(wr_err), .data_out_a(data_out_a), .data_out_b(data_out_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0, n_valid = 0, n_done = 0;
    logic [63:0] exp_a [2][DEPTH];
    logic [63:0] exp_b [2][DEPTH];
    int exp_bank;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rd_done === 1'b1) n_done++;
        if (rst_n && rd_valid === 1'b1) begin
            exp_t e;
            n_valid++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("data_a0", data_out_a[63:0], e.a);
                chk("data_b5", data_out_b[5*64 +: 64], e.b);
                chk("rd_done", 64'(rd_done), 64'(e.done));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] st, input logic [5:0] bn,
                      input int e, input logic hi, input logic [31:0] d);
        step = st;
        bram_num = bn;
        wr_addr = {4'(e), hi};
        data_received = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_start = 1'b0;
        swap = 1'b0;
    endtask

    task automatic wr64(input logic [2:0] st, input logic [5:0] bn,
                        input int e, input logic [63:0] v);
        wr(st, bn, e, 1'b0, v[31:0]);
        wr(st, bn, e, 1'b1, v[63:32]);
        if (st == 3'd1 && bn == 6'd0) exp_a[exp_bank][e] = v;
        if (st == 3'd2 && bn == 6'd5) exp_b[exp_bank][e] = v;
    endtask

    task automatic push_burst(input int bank, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.a = exp_a[bank][i];
            e.b = exp_b[bank][i];
            e.done = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (rd_busy || rd_valid); i++) tick();
        chk("idle_timeout", 64'(rd_busy), 64'(0));
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0, nd0, dc, tog;
        logic lb [30];
        logic prev;

        rst_n = 1'b0; step = '0; bram_num = '0; wr_valid = 1'b0;
        wr_addr = '0; data_received = '0; swap = 1'b0;
        rd_start = 1'b0; rd_len = '0;
        repeat (2) tick();
        chk("rst_load_bank", 64'(load_bank), 64'(0));
        chk("rst_rd_busy", 64'(rd_busy), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_done", 64'(rd_done), 64'(0));
        chk("rst_wr_err", 64'(wr_err), 64'(0));
        chk("rst_data_a", data_out_a[63:0], 64'(0));
        chk("rst_data_b", 64'(|data_out_b), 64'(0));
        rst_n = 1'b1;
        exp_bank = 0;
        tick();

        for (int e = 0; e < DEPTH; e++) begin
            wr64(3'd1, 6'd0, e, {32'hA100_0000 | 32'(e), 32'hA000_0000 | 32'(e)});
            wr64(3'd2, 6'd5, e, {32'hB100_0000 | 32'(e), 32'hB000_0000 | 32'(e)});
        end
        wr64(3'd1, 6'd0, 3, 64'h3333_4444_1111_2222);
        pulse_swap();
        exp_bank = 1;
        chk("swap_idle", 64'(load_bank), 64'(1));

        // First burst: latency and hand-computed word on entry 3.
        push_burst(0, 4);
        rd_len = 5'd4;
        rd_start = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            rd_start = 1'b0;
            chk("first_valid_latency", 64'(rd_valid), 64'(k == LAT));
        end
        wait_idle();
        chk("hold_a", data_out_a[63:0], 64'h3333_4444_1111_2222);

        // Full burst of bank 0 while bank 1 is being written.
        push_burst(0, DEPTH);
        nv0 = n_valid;
        rd_len = 5'd16;
        rd_start = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
            wr64(3'd1, 6'd0, e, {32'hC100_0000 | 32'(e), 32'hC000_0000 | 32'(e)});
            wr64(3'd2, 6'd5, e, {32'hD100_0000 | 32'(e), 32'hD000_0000 | 32'(e)});
        end
        wait_idle();
        chk("burst_valid_count", 64'(n_valid - nv0), 64'(DEPTH));

        // Swap (twice) during a burst: exactly one toggle after rd_done.
        push_burst(0, 8);
        rd_len = 5'd8;
        rd_start = 1'b1;
        dc = -1;
        tog = 0;
        prev = 1'b1;
        for (int c = 0; c < 30; c++) begin
            swap = (c == 2 || c == 4);
            tick();
            rd_start = 1'b0;
            swap = 1'b0;
            lb[c] = load_bank;
            if (rd_done && dc < 0) dc = c;
            if (lb[c] !== prev) tog++;
            prev = lb[c];
        end
        chk("swap_done_seen", 64'(dc >= 0), 64'(1));
        if (dc >= 0 && dc < 29) begin
            chk("lb_at_done", 64'(lb[dc]), 64'(1));
            chk("lb_after_done", 64'(lb[dc+1]), 64'(0));
        end
        chk("swap_toggle_count", 64'(tog), 64'(1));
        exp_bank = 0;

        // Zero-length start ignored.
        rd_len = '0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("len0_busy", 64'(rd_busy), 64'(0));
        tick();
        chk("len0_valid", 64'(rd_valid), 64'(0));

        // Over-long length clamps; start while busy ignored.
        push_burst(1, DEPTH);
        nv0 = n_valid;
        rd_len = 5'd20;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (2) tick();
        rd_len = 5'd2;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        wait_idle();
        chk("clamp_valid_count", 64'(n_valid - nv0), 64'(DEPTH));

        // Illegal writes: dropped, sticky error.
        wr(3'd2, 6'd8, 0, 1'b0, 32'hDEAD_BEEF);
        chk("wr_err_range", 64'(wr_err), 64'(1));
        wr(3'd5, 6'd0, 1, 1'b0, 32'h5555_5555);
        wr(3'd5, 6'd5, 1, 1'b1, 32'h6666_6666);
        wr(3'd0, 6'd0, 2, 1'b0, 32'h7777_7777);
        chk("wr_err_step", 64'(wr_err), 64'(1));
        pulse_swap();
        exp_bank = 1;
        push_burst(0, 3);
        rd_len = 5'd3;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        wait_idle();
        repeat (5) tick();
        chk("wr_err_sticky", 64'(wr_err), 64'(1));

        // Reset mid-burst.
        push_burst(0, 8);
        rd_len = 5'd8;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (2) tick();
        nd0 = n_done;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        nv0 = n_valid;
        repeat (12) tick();
        chk("rst_mid_valid_count", 64'(n_valid - nv0), 64'(0));
        chk("rst_mid_no_done", 64'(n_done - nd0), 64'(0));
        chk("rst_mid_load_bank", 64'(load_bank), 64'(0));
        chk("rst_mid_busy", 64'(rd_busy), 64'(0));
        chk("rst_mid_wr_err", 64'(wr_err), 64'(0));
        exp_bank = 0;
        wr(3'd5, 6'd0, 2, 1'b0, 32'h1234_5678);
        chk("wr_err_step_only", 64'(wr_err), 64'(1));

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scratch_pad_pp.md
SCRATCH_PAD_PP -- requirements
Module: scratch_pad_pp

Interface
- REQ-001 Parameter WIDTH, default 16: element width in bits.
- REQ-002 Parameter DEPTH, default 16: lane entries per bank; power of two, minimum 2.
- REQ-003 Parameter SYS_HEIGHT, default 1: number of activation lanes.
- REQ-004 Parameter SYS_WIDTH, default 64: number of weight lanes.
- REQ-005 Derived constants: LANE_W = 4*WIDTH (64 at default), AW = clog2(DEPTH).
- REQ-006 clk  in  1  single clock; all logic on its rising edge.
- REQ-007 rst_n  in  1  reset; synchronous, active-low.
- REQ-008 step  in  3  write target: 1 = activation, 2 = weight, any other value ignores writes.
- REQ-009 bram_num  in  6  lane select for a write.
- REQ-010 wr_valid  in  1  write strobe.
- REQ-011 wr_addr  in  AW+1  write address; bit 0 selects the 32-bit half (0 = low, 1 = high), upper bits select the entry.
- REQ-012 data_received  in  32  write data.
- REQ-013 swap  in  1  single-cycle pulse requesting a bank exchange.
- REQ-014 rd_start  in  1  single-cycle pulse that starts a read burst.
- REQ-015 rd_len  in  AW+1  burst length, 1..DEPTH; sampled on rd_start.
- REQ-016 load_bank  out  1  bank currently targeted by writes.
- REQ-017 rd_busy  out  1  read sequencer is not IDLE.
- REQ-018 rd_valid  out  1  data_out_a and data_out_b are valid this cycle.
- REQ-019 rd_done  out  1  one-cycle pulse, coincident with the last rd_valid of a burst.
- REQ-020 wr_err  out  1  sticky error flag.
- REQ-021 data_out_a  out  SYS_HEIGHT*LANE_W  activation lanes; lane i occupies bits [LANE_W*i +: LANE_W].
- REQ-022 data_out_b  out  SYS_WIDTH*LANE_W  weight lanes; same packing as data_out_a.

Function
- REQ-023 Two banks, each holding SYS_HEIGHT activation lanes and SYS_WIDTH weight lanes of DEPTH x LANE_W; writes go only to bank load_bank, reads come only from bank ~load_bank.
- REQ-024 A write is performed when wr_valid is high, step is 1 or 2, and bram_num is below the lane count for that target; it updates the selected 32-bit half of the selected entry.
- REQ-025 A write with wr_valid high and bram_num out of range, or with step not equal to 1 or 2, is dropped and sets wr_err.
- REQ-026 Read sequencer states: IDLE -> (rd_start) -> RUN -> (last address issued) -> DRAIN -> (last data out) -> IDLE.
- REQ-027 In RUN, the sequencer issues addresses 0..rd_len-1, one per cycle.
- REQ-028 Read latency is 1 cycle from address issue to rd_valid.
- REQ-029 rd_start while rd_busy is high is ignored.
- REQ-030 rd_start with rd_len = 0 is ignored; rd_len > DEPTH is clamped to DEPTH.
- REQ-031 A swap pulse while IDLE with no rd_start in the same cycle toggles load_bank on the next edge.
- REQ-032 A swap pulse while busy is held pending and takes effect in the cycle after rd_done.
- REQ-033 A second swap while one is pending is absorbed, not counted.
- REQ-034 When swap and rd_start arrive in the same IDLE cycle, rd_start wins and the swap becomes pending.
- REQ-035 A write in the cycle load_bank toggles goes to the old bank.
- REQ-036 data_out_a and data_out_b hold their last value when rd_valid is low.

Reset
- REQ-037 While rst_n is low at a clock edge: sequencer goes to IDLE; load_bank, rd_busy, rd_valid, rd_done, wr_err and the pending swap all clear to 0; data_out_a and data_out_b clear to 0.
- REQ-038 Memory contents are not reset.
- REQ-039 Reset during RUN or DRAIN aborts the burst with no rd_done.

Configuration
- REQ-040 With macro SCRATCH_PAD_PP_OUTREG_EN defined: an output register stage is added, read latency becomes 2, and rd_valid and rd_done are delayed to match.
- REQ-041 Without SCRATCH_PAD_PP_OUTREG_EN: latency is 1 as stated in REQ-028.

Structure
- REQ-042 Shared package spad_pkg holds the step codes STEP_LOAD_ACT = 1 and STEP_LOAD_WGT = 2 and the sequencer state enum.
- REQ-043 One sub-module, spad_lane_ram: simple dual-port memory of DEPTH x LANE_W with per-32-bit-half write enables and a 1-cycle registered read.
- REQ-044 spad_lane_ram is instantiated 2*(SYS_HEIGHT+SYS_WIDTH) times.

Verification
- REQ-045 Write act lane 0 entry 3 with low half 0x1111_2222 and high half 0x3333_4444, swap, rd_start with rd_len=4 -> fourth rd_valid shows data_out_a[63:0] = 0x3333_4444_1111_2222, with rd_done on that cycle.
- REQ-046 Fill bank 0, swap, then write bank 1 while reading bank 0 with rd_len=DEPTH -> read data is unaffected by the writes; exactly DEPTH rd_valid cycles.
- REQ-047 swap pulse at cycle 2 of a burst with rd_len=8 -> load_bank toggles the cycle after rd_done, exactly once.
- REQ-048 Write with step=2 and bram_num=SYS_WIDTH, then a write with step=5 -> no memory change; wr_err = 1 and stays 1 until reset.
- REQ-049 rst_n low for 1 cycle mid-burst -> rd_valid = 0 and rd_done never asserted; load_bank = 0.
- REQ-050 Repeat REQ-045 with SCRATCH_PAD_PP_OUTREG_EN defined -> identical data, with first rd_valid 2 cycles after rd_start.
